// File: rtl/async_mmap_responder.sv
// async_mmap_responder
//   AXI4 slave that terminates a master's AW/W/B and AR/R channels on an
//   internal word-addressed memory of 2^MemDepthLog words of DataWidth bits.
//   INCR bursts up to 256 beats, one outstanding transaction per direction,
//   independent write and read engines running concurrently.
//
// Ports
//   clk, rst_n        : rising-edge clock, asynchronous active-low reset
//   s_axi_AW*         : write address (VALID/READY/ADDR/ID/LEN/SIZE/BURST)
//   s_axi_W*          : write data (VALID/READY/DATA/STRB/LAST)
//   s_axi_B*          : write response (VALID/READY/RESP/ID)
//   s_axi_AR*         : read address (VALID/READY/ADDR/ID/LEN/SIZE/BURST)
//   s_axi_R*          : read data (VALID/READY/DATA/LAST/ID/RESP)
//
// A request is bad when its word index is beyond the memory, the burst is
// not INCR, or the size is not the full bus width. Bad writes consume all
// beats without touching memory; bad reads return zero data. Both answer
// SLVERR. Memory contents are not reset.
module async_mmap_responder #(
  parameter int AddrWidth         = 64,
  parameter int DataWidth         = 512,
  parameter int DataWidthBytesLog = 6,
  parameter int MemDepthLog       = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s_axi_AWVALID,
  output logic                   s_axi_AWREADY,
  input  logic [AddrWidth-1:0]   s_axi_AWADDR,
  input  logic                   s_axi_AWID,
  input  logic [7:0]             s_axi_AWLEN,
  input  logic [2:0]             s_axi_AWSIZE,
  input  logic [1:0]             s_axi_AWBURST,
  input  logic                   s_axi_WVALID,
  output logic                   s_axi_WREADY,
  input  logic [DataWidth-1:0]   s_axi_WDATA,
  input  logic [DataWidth/8-1:0] s_axi_WSTRB,
  input  logic                   s_axi_WLAST,
  output logic                   s_axi_BVALID,
  input  logic                   s_axi_BREADY,
  output logic [1:0]             s_axi_BRESP,
  output logic                   s_axi_BID,
  input  logic                   s_axi_ARVALID,
  output logic                   s_axi_ARREADY,
  input  logic [AddrWidth-1:0]   s_axi_ARADDR,
  input  logic                   s_axi_ARID,
  input  logic [7:0]             s_axi_ARLEN,
  input  logic [2:0]             s_axi_ARSIZE,
  input  logic [1:0]             s_axi_ARBURST,
  output logic                   s_axi_RVALID,
  input  logic                   s_axi_RREADY,
  output logic [DataWidth-1:0]   s_axi_RDATA,
  output logic                   s_axi_RLAST,
  output logic                   s_axi_RID,
  output logic [1:0]             s_axi_RRESP
);
  localparam int                   NB     = DataWidth / 8;
  localparam int                   Depth  = 1 << MemDepthLog;
  localparam logic [2:0]           Size   = 3'(DataWidthBytesLog);
  localparam logic [1:0]           Okay   = 2'b00;
  localparam logic [1:0]           SlvErr = 2'b10;
  localparam logic [MemDepthLog-1:0] IdxOne = 1;

  typedef enum logic [1:0] {WIDLE, WDATA, WRESP} wstate_t;
  typedef enum logic       {RIDLE, RDATA}        rstate_t;

  logic [DataWidth-1:0] r_mem [Depth];

  // ---------------- request decode ----------------
  logic [AddrWidth-1:0]   w_aw_word, w_ar_word;
  logic [MemDepthLog-1:0] w_aw_idx,  w_ar_idx;
  logic                   w_aw_bad,  w_ar_bad;

  assign w_aw_word = s_axi_AWADDR >> DataWidthBytesLog;
  assign w_ar_word = s_axi_ARADDR >> DataWidthBytesLog;
  assign w_aw_idx  = w_aw_word[MemDepthLog-1:0];
  assign w_ar_idx  = w_ar_word[MemDepthLog-1:0];
  assign w_aw_bad  = ((w_aw_word >> MemDepthLog) != '0) || (s_axi_AWBURST != 2'b01) ||
                     (s_axi_AWSIZE != Size);
  assign w_ar_bad  = ((w_ar_word >> MemDepthLog) != '0) || (s_axi_ARBURST != 2'b01) ||
                     (s_axi_ARSIZE != Size);

  // ---------------- write engine ----------------
  wstate_t                r_wstate;
  logic                   r_awready, r_wready, r_bvalid, r_bid, r_wbad, r_werr;
  logic [1:0]             r_bresp;
  logic [MemDepthLog-1:0] r_widx;
  logic [7:0]             r_wlen, r_wcnt;
  logic                   w_wbeat, w_wcnt_last, w_wlast_mis, w_wr_en;

  // WREADY is only ever high in WDATA, so it doubles as the state qualifier.
  assign w_wbeat     = r_wready & s_axi_WVALID;
  assign w_wcnt_last = (r_wcnt == r_wlen);
  assign w_wlast_mis = s_axi_WLAST != w_wcnt_last;
  assign w_wr_en     = w_wbeat & ~r_wbad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wstate  <= WIDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= Okay;
      r_bid     <= 1'b0;
      r_widx    <= '0;
      r_wlen    <= '0;
      r_wcnt    <= '0;
      r_wbad    <= 1'b0;
      r_werr    <= 1'b0;
    end else begin
      case (r_wstate)
        WIDLE: begin
          if (r_awready && s_axi_AWVALID) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b1;
            r_widx    <= w_aw_idx;
            r_wlen    <= s_axi_AWLEN;
            r_wcnt    <= '0;
            r_wbad    <= w_aw_bad;
            r_werr    <= 1'b0;
            r_bid     <= s_axi_AWID;
            r_wstate  <= WDATA;
          end else begin
            r_awready <= 1'b1;
          end
        end
        WDATA: begin
          if (w_wbeat) begin
            r_widx <= r_widx + IdxOne;
            r_wcnt <= r_wcnt + 8'd1;
            if (w_wlast_mis) r_werr <= 1'b1;
            // The beat count, not WLAST, ends the burst.
            if (w_wcnt_last) begin
              r_wready <= 1'b0;
              r_bvalid <= 1'b1;
              r_bresp  <= (r_wbad || r_werr || w_wlast_mis) ? SlvErr : Okay;
              r_wstate <= WRESP;
            end
          end
        end
        WRESP: begin
          if (s_axi_BREADY) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wstate  <= WIDLE;
          end
        end
        default: r_wstate <= WIDLE;
      endcase
    end
  end

  // Memory array has no reset; a same-edge read of this word sees the old value.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (s_axi_WSTRB[b]) r_mem[r_widx][b*8 +: 8] <= s_axi_WDATA[b*8 +: 8];
      end
    end
  end

  // ---------------- read engine ----------------
  rstate_t                r_rstate;
  logic                   r_arready, r_rvalid, r_rlast, r_rid, r_rbad;
  logic [1:0]             r_rresp;
  logic [DataWidth-1:0]   r_rdata;
  logic [MemDepthLog-1:0] r_ridx, w_ridx_nxt;
  logic [7:0]             r_rlen, r_rcnt;

  assign w_ridx_nxt = r_ridx + IdxOne;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rstate  <= RIDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rlast   <= 1'b0;
      r_rid     <= 1'b0;
      r_rresp   <= Okay;
      r_ridx    <= '0;
      r_rlen    <= '0;
      r_rcnt    <= '0;
      r_rbad    <= 1'b0;
    end else begin
      case (r_rstate)
        RIDLE: begin
          if (r_arready && s_axi_ARVALID) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b1;
            r_ridx    <= w_ar_idx;
            r_rlen    <= s_axi_ARLEN;
            r_rcnt    <= '0;
            r_rbad    <= w_ar_bad;
            r_rid     <= s_axi_ARID;
            r_rresp   <= w_ar_bad ? SlvErr : Okay;
            r_rlast   <= (s_axi_ARLEN == 8'd0);
            r_rdata   <= w_ar_bad ? '0 : r_mem[w_ar_idx];
            r_rstate  <= RDATA;
          end else begin
            r_arready <= 1'b1;
          end
        end
        RDATA: begin
          if (s_axi_RREADY) begin
            if (r_rcnt == r_rlen) begin
              r_rvalid  <= 1'b0;
              r_rlast   <= 1'b0;
              r_arready <= 1'b1;
              r_rstate  <= RIDLE;
            end else begin
              r_rcnt  <= r_rcnt + 8'd1;
              r_ridx  <= w_ridx_nxt;
              r_rlast <= ((r_rcnt + 8'd1) == r_rlen);
              r_rdata <= r_rbad ? '0 : r_mem[w_ridx_nxt];
            end
          end
        end
        default: r_rstate <= RIDLE;
      endcase
    end
  end

  assign s_axi_AWREADY = r_awready;
  assign s_axi_WREADY  = r_wready;
  assign s_axi_BVALID  = r_bvalid;
  assign s_axi_BRESP   = r_bresp;
  assign s_axi_BID     = r_bid;
  assign s_axi_ARREADY = r_arready;
  assign s_axi_RVALID  = r_rvalid;
  assign s_axi_RDATA   = r_rdata;
  assign s_axi_RLAST   = r_rlast;
  assign s_axi_RID     = r_rid;
  assign s_axi_RRESP   = r_rresp;

endmodule

// File: doc/async_mmap_responder.md
# async_mmap_responder

AXI4 slave responder that terminates an AXI4 master's five channels on an internal word-addressed memory. It handles INCR bursts of up to 256 beats, with independent write (AW/W/B) and read (AR/R) engines. It is the far end of the burst-inferring memory-mapped master and serves as an on-chip memory model for simulation and for small on-chip buffers. Single outstanding transaction per direction.

## Interface
- AddrWidth, 64: AXI address width.
- DataWidth, 512: AXI data width.
- DataWidthBytesLog, 6: log2(DataWidth/8); also the only legal AxSIZE.
- MemDepthLog, 10: memory depth is 2^MemDepthLog words of DataWidth bits.

- clk  in  1  clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- s_axi_AWVALID in 1, s_axi_AWREADY out 1, s_axi_AWADDR in AddrWidth, s_axi_AWID in 1, s_axi_AWLEN in 8, s_axi_AWSIZE in 3, s_axi_AWBURST in 2: write address.
- s_axi_WVALID in 1, s_axi_WREADY out 1, s_axi_WDATA in DataWidth, s_axi_WSTRB in DataWidth/8, s_axi_WLAST in 1: write data.
- s_axi_BVALID out 1, s_axi_BREADY in 1, s_axi_BRESP out 2, s_axi_BID out 1: write response.
- s_axi_ARVALID in 1, s_axi_ARREADY out 1, s_axi_ARADDR in AddrWidth, s_axi_ARID in 1, s_axi_ARLEN in 8, s_axi_ARSIZE in 3, s_axi_ARBURST in 2: read address.
- s_axi_RVALID out 1, s_axi_RREADY in 1, s_axi_RDATA out DataWidth, s_axi_RLAST out 1, s_axi_RID out 1, s_axi_RRESP out 2: read data.
- AxLOCK/AxCACHE/AxPROT/AxQOS are not ports. The master drives them constant, and they are ignored.

## Operation
- Word index = AxADDR >> DataWidthBytesLog. Low DataWidthBytesLog address bits are ignored, so every access is treated as aligned.
- A request is bad if any of these hold:
  - the word index is ≥ 2^MemDepthLog;
  - AxBURST != 2'b01;
  - AxSIZE != DataWidthBytesLog.
- Within a burst, the index increments modulo 2^MemDepthLog.
- Write FSM states and transitions:
  - WIDLE: AWREADY=1. On AW handshake, latch index, len=AWLEN, id and the bad flag, clear beat counter cnt, then go to WDATA.
  - WDATA: WREADY=1. Each W handshake writes mem[index], byte lanes enabled by WSTRB. The write is suppressed if the burst is bad.
  - WDATA, beat accounting: each beat increments index and cnt. If WLAST != (cnt==len) on a beat, set the err flag.
  - WDATA exit: on the beat where cnt==len, go to WRESP. WLAST does not end the burst early; the beat count alone decides.
  - WRESP: BVALID=1, BID=latched id, BRESP=2'b10 (SLVERR) if bad or err, else 2'b00. On BREADY, go to WIDLE.
- Read FSM states and transitions:
  - RIDLE: ARREADY=1. On AR handshake, latch len, id and bad, clear cnt, load RDATA with mem[start] (zero if bad), then go to RDATA.
  - RDATA: RVALID=1, RLAST=(cnt==len), RRESP=SLVERR if bad else OKAY, RID=latched id.
  - RDATA handshake: on R handshake with cnt!=len, increment cnt and index and load RDATA with mem[next] (zero if bad). With cnt==len, go to RIDLE.
- Read and write engines run concurrently.
- Same-word collision: a W beat and an RDATA load on the same edge to the same word gives the read the old value.
- Memory contents are not reset.

## Timing
- Reset (rst_n low, asynchronous): both FSMs go to idle.
- All ready/valid outputs are registered and are 0 while in reset. AWREADY/ARREADY rise on the first clk edge after rst_n deasserts.
- Reset values of the other outputs: BRESP, BID, RDATA, RLAST, RID and RRESP are 0.
- Reset asserted mid-burst aborts the burst immediately. Beats already written stay in memory, and no B or R response is issued.
- Write timing:
  - AW handshake at edge N: AWREADY low from N, WREADY high from N.
  - A burst of L+1 beats with WVALID held takes L+1 cycles.
  - After the last W beat at edge M, BVALID is high from M.
  - After the B handshake at edge K, AWREADY is high from K.
- Read timing:
  - AR handshake at edge N: RVALID is high with beat 0 from N, i.e. one cycle of latency.
  - Beats are back-to-back while RREADY is held.
  - After the final beat handshake at edge M, ARREADY is high from M. The next AR is accepted at M+1 at earliest.
- Stall and outstanding rules:
  - RVALID/RDATA/RLAST and BVALID/BRESP stay stable until accepted, regardless of the master.
  - WVALID low stalls the write burst indefinitely.
  - AW/AR are never accepted while the respective engine is busy, so there is at most one outstanding transaction per direction.

## Test plan
- Single write, then read: AW addr 0x40 len 0; W data A with all-ones strobe and WLAST=1 → BRESP 0, BID echoed. Then AR 0x40 len 0 → RDATA=A, RLAST=1, RRESP 0, with RVALID one cycle after the AR edge.
- 16-beat burst: write at word 5, data i+1 for beat i, with RREADY/WVALID held → WREADY low never, B one cycle after beat 16.
- 16-beat read-back with RREADY held → 16 consecutive RVALID cycles, RLAST only on beat 16.
- Wrap and strobe:
  - 4-beat write at word 2^MemDepthLog−2 → words D−2, D−1, 0, 1 are written.
  - Re-write word 0 with WSTRB=1 → only byte 0 changes.
- Errors:
  - ARBURST=2'b10 → 1-beat RDATA=0, RRESP 2'b10.
  - Out-of-range AWADDR → memory unchanged, BRESP 2'b10.
  - WLAST early on beat 2 of 4 → all 4 beats consumed, BRESP 2'b10.
- Backpressure and reset:
  - Random RREADY/BREADY/WVALID → outputs stable while unaccepted, data intact.
  - rst_n pulled low mid-read → RVALID 0 immediately, ARREADY 1 one edge after release.
